// File: rtl/cu_iram_resp_if.sv
// Fetch port and NoC fill stream of the CU instruction-memory responder.
interface cu_iram_resp_if #(
  parameter int AW = 10
);
  // Fetch: a request is taken when instr_req_i & instr_gnt_o at a rising edge;
  // the word follows with instr_rvalid_o exactly one cycle later.
  // Fill: a beat is taken when load_vld_i & load_rdy_o at a rising edge;
  // the source holds data/last stable until that edge.
  logic            instr_req_i;
  logic            instr_gnt_o;
  logic [31:0]     instr_addr_i;
  logic            instr_rvalid_o;
  logic [31:0]     instr_rdata_o;
  logic            load_start_i;
  logic [AW-1:0]   load_base_i;
  logic            load_vld_i;
  logic            load_last_i;
  logic [255:0]    load_data_i;
  logic            load_rdy_o;
  logic            load_busy_o;
  logic            load_done_o;
  logic            load_err_o;
  logic            fetch_err_o;
  logic            dbg_state;

  modport slave (
    input  instr_req_i, instr_addr_i, load_start_i, load_base_i,
           load_vld_i, load_last_i, load_data_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, load_rdy_o,
           load_busy_o, load_done_o, load_err_o, fetch_err_o, dbg_state
  );

  modport master (
    output instr_req_i, instr_addr_i, load_start_i, load_base_i,
           load_vld_i, load_last_i, load_data_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, load_rdy_o,
           load_busy_o, load_done_o, load_err_o, fetch_err_o, dbg_state
  );
endinterface

// File: rtl/cu_iram_resp.sv
// Instruction SRAM serving the core fetch port, filled in 8-word rows from the NoC.
module cu_iram_resp #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          AW          = $clog2(DEPTH_WORDS),
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  cu_iram_resp_if.slave   bus
);
  localparam int ROWS = DEPTH_WORDS / 8;
  localparam int RW   = AW - 3;

  typedef enum logic {SERVE = 1'b0, LOAD = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [31:0]     mem [8][ROWS];
  logic [RW:0]     row_ptr;
  logic [31:0]     off;
  logic            in_range;
  logic [2:0]      rd_bank;
  logic [RW-1:0]   rd_row;
  logic            gnt, rdy, busy, beat, row_ok;
  logic            rvalid_q, ferr_q, done_q, err_q;
  logic [31:0]     rdata_q;
  logic            unused_bits;

  assign off      = bus.instr_addr_i - BASE_ADDR;
  assign in_range = off[31:2] < 30'(DEPTH_WORDS);
  assign rd_bank  = off[4:2];
  assign rd_row   = off[AW+1:5];
  assign beat     = (state == LOAD) && bus.load_vld_i;
  // The extra MSB of row_ptr marks "past the end"; it saturates there so no wrap.
  assign row_ok   = ~row_ptr[RW];
  assign unused_bits = ^{off[1:0], bus.load_base_i[2:0]};

  always_comb begin
    state_nxt = state;
    gnt       = 1'b0;
    rdy       = 1'b0;
    busy      = 1'b0;
    case (state)
      SERVE: begin
        gnt = bus.instr_req_i & ~bus.load_start_i;
        if (bus.load_start_i) state_nxt = LOAD;
      end
      LOAD: begin
        rdy  = 1'b1;
        busy = 1'b1;
        if (bus.load_vld_i && bus.load_last_i) state_nxt = SERVE;
      end
      default: state_nxt = SERVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= SERVE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      ferr_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      row_ptr  <= '0;
    end else begin
      rvalid_q <= gnt;
      ferr_q   <= gnt & ~in_range;
      done_q   <= beat & bus.load_last_i;
      if (gnt) rdata_q <= in_range ? mem[rd_bank][rd_row] : NOP_WORD;
      if (state == SERVE && bus.load_start_i) begin
        row_ptr <= {1'b0, bus.load_base_i[AW-1:3]};
        err_q   <= 1'b0;
      end else if (beat) begin
        if (row_ok) row_ptr <= row_ptr + 1'b1;
        else        err_q   <= 1'b1;
      end
    end
  end

  // One row per beat: word k of the beat lands in bank k.
  always_ff @(posedge clk) begin
    if (!rst && beat && row_ok) begin
      for (int k = 0; k < 8; k++) mem[k][row_ptr[RW-1:0]] <= bus.load_data_i[32*k +: 32];
    end
  end

  assign bus.instr_gnt_o    = gnt;
  assign bus.instr_rvalid_o = rvalid_q;
  assign bus.instr_rdata_o  = rdata_q;
  assign bus.fetch_err_o    = ferr_q;
  assign bus.load_rdy_o     = rdy;
  assign bus.load_busy_o    = busy;
  assign bus.load_done_o    = done_q;
  assign bus.load_err_o     = err_q;
  assign bus.dbg_state      = state;
endmodule

// File: tb/tb_cu_iram_resp.sv
// Bench for cu_iram_resp: fetch vector table, fill/overflow/reset sequences, scoreboarded reads.
module tb_cu_iram_resp;
  localparam int          DEPTH = 1024;
  localparam int          AW    = 10;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cu_iram_resp_if #(.AW(AW)) bus();

  cu_iram_resp #(
    .DEPTH_WORDS(DEPTH), .AW(AW), .BASE_ADDR(32'h0000_0000), .NOP_WORD(NOP)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [32:0] exp_q[$];
  logic [32:0] e_mon;
  logic [31:0] exp_mem [DEPTH];
  int          m_ptr;
  logic        m_err;
  vec_t        vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every rvalid cycle pops one expected {fetch_err, rdata}.
  always @(negedge clk) begin
    if (bus.instr_rvalid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rvalid_unexpected", 32'(bus.instr_rvalid_o), 32'd0);
      end else begin
        e_mon = exp_q.pop_front();
        check("rdata", bus.instr_rdata_o, e_mon[31:0]);
        check("fetch_err", 32'(bus.fetch_err_o), 32'(e_mon[32]));
      end
    end else if (!rst) begin
      check("fetch_err_idle", 32'(bus.fetch_err_o), 32'd0);
    end
  end

  task automatic fetch(input logic [31:0] addr, input logic [31:0] d, input logic e);
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = addr;
    #1;
    check("gnt", 32'(bus.instr_gnt_o), 32'd1);
    if (bus.instr_gnt_o) exp_q.push_back({e, d});
    tick();
    check("rvalid_next", 32'(bus.instr_rvalid_o), 32'd1);
  endtask

  task automatic start_fill(input logic [AW-1:0] base);
    bus.load_start_i = 1'b1;
    bus.load_base_i  = base;
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h0;
    #1;
    check("gnt_at_start", 32'(bus.instr_gnt_o), 32'd0);
    tick();
    bus.load_start_i = 1'b0;
    check("busy_in_load", 32'(bus.load_busy_o), 32'd1);
    check("rdy_in_load", 32'(bus.load_rdy_o), 32'd1);
    check("err_cleared", 32'(bus.load_err_o), 32'd0);
    m_ptr = int'(base) & ~7;
    m_err = 1'b0;
  endtask

  task automatic fill_beat(input logic [31:0] w0, input logic last);
    logic [255:0] d;
    for (int k = 0; k < 8; k++) d[32*k +: 32] = w0 + 32'(k);
    bus.load_data_i = d;
    bus.load_vld_i  = 1'b1;
    bus.load_last_i = last;
    #1;
    check("rdy_beat", 32'(bus.load_rdy_o), 32'd1);
    check("gnt_in_load", 32'(bus.instr_gnt_o), 32'd0);
    tick();
    bus.load_vld_i  = 1'b0;
    bus.load_last_i = 1'b0;
    if (m_ptr < DEPTH) begin
      for (int k = 0; k < 8; k++) exp_mem[m_ptr + k] = w0 + 32'(k);
    end else begin
      m_err = 1'b1;
    end
    m_ptr += 8;
    if (last) begin
      bus.instr_req_i = 1'b0;
      #1;
      check("done_pulse", 32'(bus.load_done_o), 32'd1);
      check("busy_after", 32'(bus.load_busy_o), 32'd0);
      check("rdy_after", 32'(bus.load_rdy_o), 32'd0);
      check("err_after", 32'(bus.load_err_o), 32'(m_err));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_0000, 32'h1000_0000, 1'b0};
    vecs[1] = '{32'h0000_0004, 32'h1000_0001, 1'b0};
    vecs[2] = '{32'h0000_0020, 32'h2000_0000, 1'b0};
    vecs[3] = '{32'h0000_003C, 32'h2000_0007, 1'b0};
    vecs[4] = '{32'h0000_1000, NOP,           1'b1};
    vecs[5] = '{32'h0000_001E, 32'h1000_0007, 1'b0};
    vecs[6] = '{32'hFFFF_FFFC, NOP,           1'b1};
    vecs[7] = '{32'h0000_0008, 32'h1000_0002, 1'b0};

    bus.instr_req_i  = 1'b0;
    bus.instr_addr_i = '0;
    bus.load_start_i = 1'b0;
    bus.load_base_i  = '0;
    bus.load_vld_i   = 1'b0;
    bus.load_last_i  = 1'b0;
    bus.load_data_i  = '0;
    rst = 1'b1;
    tick();
    tick();
    check("rst_rvalid", 32'(bus.instr_rvalid_o), 32'd0);
    check("rst_rdata", bus.instr_rdata_o, 32'd0);
    check("rst_rdy", 32'(bus.load_rdy_o), 32'd0);
    check("rst_busy", 32'(bus.load_busy_o), 32'd0);
    check("rst_done", 32'(bus.load_done_o), 32'd0);
    check("rst_err", 32'(bus.load_err_o), 32'd0);
    check("rst_ferr", 32'(bus.fetch_err_o), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'd0);
    rst = 1'b0;

    // First fill: words 0..15.
    start_fill(10'd0);
    fill_beat(32'h1000_0000, 1'b0);
    fill_beat(32'h2000_0000, 1'b1);
    tick();
    check("done_one_cycle", 32'(bus.load_done_o), 32'd0);

    // Back-to-back fetch table, including out-of-range and low-bit-ignored addresses.
    for (int i = 0; i < 8; i++) fetch(vecs[i].addr, vecs[i].data, vecs[i].err);
    bus.instr_req_i = 1'b0;
    tick();
    tick();

    // Overflow fill from 1021 (aligned to 1016); fetch right in the done cycle.
    start_fill(10'd1021);
    fill_beat(32'h4000_0000, 1'b0);
    fill_beat(32'h5000_0000, 1'b1);
    fetch(32'd4 * 32'd1016, 32'h4000_0000, 1'b0);
    fetch(32'd4 * 32'd1023, 32'h4000_0007, 1'b0);
    bus.instr_req_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("err_sticky", 32'(bus.load_err_o), 32'd1);
    end

    // Grant one cycle before start returns old data; req held through LOAD.
    fetch(32'h0000_0004, 32'h1000_0001, 1'b0);
    start_fill(10'd16);
    for (int i = 0; i < 2; i++) begin
      #1;
      check("gnt_held_off", 32'(bus.instr_gnt_o), 32'd0);
      check("rdy_idle_load", 32'(bus.load_rdy_o), 32'd1);
      tick();
    end
    fill_beat(32'h6000_0000, 1'b1);

    // Beat offered while serving must not be taken.
    bus.load_data_i = {8{32'hDEAD_BEEF}};
    bus.load_vld_i  = 1'b1;
    bus.load_last_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("rdy_in_serve", 32'(bus.load_rdy_o), 32'd0);
      check("busy_in_serve", 32'(bus.load_busy_o), 32'd0);
      tick();
    end
    bus.load_vld_i  = 1'b0;
    bus.load_last_i = 1'b0;
    fetch(32'd4 * 32'd16, 32'h6000_0000, 1'b0);
    fetch(32'd4 * 32'd0, 32'h1000_0000, 1'b0);
    bus.instr_req_i = 1'b0;
    tick();

    // Reset after the first of three beats.
    start_fill(10'd0);
    fill_beat(32'h3000_0000, 1'b0);
    rst = 1'b1;
    tick();
    check("rst_mid_rdy", 32'(bus.load_rdy_o), 32'd0);
    check("rst_mid_busy", 32'(bus.load_busy_o), 32'd0);
    check("rst_mid_rvalid", 32'(bus.instr_rvalid_o), 32'd0);
    rst = 1'b0;
    bus.instr_req_i = 1'b0;
    tick();
    fetch(32'h0000_0000, 32'h3000_0000, 1'b0);
    fetch(32'h0000_0020, 32'h2000_0000, 1'b0);
    fetch(32'h0000_003C, 32'h2000_0007, 1'b0);

    // Random fetches over the written regions and out of range.
    for (int i = 0; i < 24; i++) begin
      int r;
      int idx;
      r = int'($urandom_range(0, 3));
      if (r == 2) begin
        fetch(32'h0000_1000 + 32'($urandom_range(0, 1000)) * 32'd4, NOP, 1'b1);
      end else begin
        idx = (r == 1) ? int'($urandom_range(1016, 1023)) : int'($urandom_range(0, 23));
        fetch(32'(idx) * 32'd4 + 32'($urandom_range(0, 3)), exp_mem[idx], 1'b0);
      end
    end
    bus.instr_req_i = 1'b0;
    repeat (3) tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
